// File: rtl/first_zero_pipelined.sv
// Pipelined radix-4 find-first-zero encoder for WIDTH-bit occupancy words.
// Reports the lowest 0 bit of each word STAGES cycles later, one word per cycle.
// Optional feature: define FIRST_ZERO_START_EN to add a `start` port that
// treats every bit below `start` as occupied.
module first_zero_pipelined #(
    parameter int WIDTH  = 13,
    parameter int STAGES = ($clog2(WIDTH) + 1) / 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
`ifdef FIRST_ZERO_START_EN
    input  logic [$clog2(WIDTH)-1:0] start,
`endif
    input  logic                     validIn,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     found,
    output logic                     validOut
);

    localparam int IW = $clog2(WIDTH);
    localparam int PW = 1 << (2 * STAGES);        // padded word width, 4^STAGES
    localparam int NG = 1 << (2 * (STAGES - 1));  // groups at the input-side level
    localparam int XW = 2 * STAGES;               // full accumulated index width

    // Level l only uses the first 4^l entries; level 0 entry 0 is the result.
    logic [PW-1:0]                     padded;
    logic [STAGES-1:0][NG-1:0]         az_q, az_d;
    logic [STAGES-1:0][NG-1:0][XW-1:0] ix_q, ix_d;
    logic [STAGES:1]                   vld_pipe;
    logic                              unused_bits;

    // Pad to 4^STAGES with occupied bits and mask positions below start.
    always_comb begin
        padded = '1;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef FIRST_ZERO_START_EN
            padded[i] = in[i] | (i < int'(start));
`else
            padded[i] = in[i];
`endif
        end
    end

    // Next value of every tree level: leaves from the padded word, inner
    // nodes from the registered children one level closer to the input.
    always_comb begin : tree
        logic [3:0] grp;
        logic [1:0] sel;
        grp  = '0;
        sel  = '0;
        az_d = '0;
        ix_d = '0;
        for (int g = 0; g < NG; g++) begin
            grp = padded[4*g +: 4];
            sel = 2'd0;
            for (int b = 3; b >= 0; b--)
                if (!grp[b]) sel = 2'(b);
            az_d[STAGES-1][g] = ~&grp;
            ix_d[STAGES-1][g] = XW'(sel);
        end
        for (int l = STAGES - 2; l >= 0; l--) begin
            for (int g = 0; g < (1 << (2 * l)); g++) begin
                sel = 2'd0;
                for (int k = 3; k >= 0; k--)
                    if (az_q[l+1][4*g+k]) sel = 2'(k);
                az_d[l][g] = |az_q[l+1][4*g +: 4];
                ix_d[l][g] = (XW'(sel) << (2 * (STAGES - 1 - l)))
                           | ix_q[l+1][4*g + int'(sel)];
            end
        end
        // No zero anywhere: report index 0 rather than whatever child 0 held.
        if (!az_d[0][0]) ix_d[0][0] = '0;
    end

    // Tree registers and the valid sideband shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            az_q     <= '0;
            ix_q     <= '0;
            vld_pipe <= '0;
        end else begin
            az_q     <= az_d;
            ix_q     <= ix_d;
            vld_pipe <= STAGES'({vld_pipe, validIn});
        end
    end

    assign found    = az_q[0][0];
    assign index    = ix_q[0][0][IW-1:0];
    assign validOut = vld_pipe[STAGES];

    // Unused tree slots and the index bits above IW (always zero since index < WIDTH).
    assign unused_bits = ^{az_q, ix_q};

endmodule

// File: tb/tb_first_zero_pipelined.sv
// Self-checking bench for first_zero_pipelined: directed cases at WIDTH=13 and
// a randomized sweep at WIDTH=5, 13 and 64 against a lowest-zero model.
module tb_first_zero_pipelined;

    localparam int W13 = 13, IW13 = 4, S13 = 2;
    localparam int W5  = 5,  IW5  = 3, S5  = 2;
    localparam int W64 = 64, IW64 = 6, S64 = 3;
    localparam int N   = 300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [W13-1:0]  in13;  logic [IW13-1:0] i13, st13;  logic v13in, f13, vo13;
    logic [W5-1:0]   in5;   logic [IW5-1:0]  i5,  st5;   logic v5in,  f5,  vo5;
    logic [W64-1:0]  in64;  logic [IW64-1:0] i64, st64;  logic v64in, f64, vo64;

    int n_cmp = 0;
    int n_bad = 0;

    first_zero_pipelined #(.WIDTH(W13)) dut13 (
        .clk(clk), .reset(reset), .in(in13),
`ifdef FIRST_ZERO_START_EN
        .start(st13),
`endif
        .validIn(v13in), .index(i13), .found(f13), .validOut(vo13));

    first_zero_pipelined #(.WIDTH(W5)) dut5 (
        .clk(clk), .reset(reset), .in(in5),
`ifdef FIRST_ZERO_START_EN
        .start(st5),
`endif
        .validIn(v5in), .index(i5), .found(f5), .validOut(vo5));

    first_zero_pipelined #(.WIDTH(W64)) dut64 (
        .clk(clk), .reset(reset), .in(in64),
`ifdef FIRST_ZERO_START_EN
        .start(st64),
`endif
        .validIn(v64in), .index(i64), .found(f64), .validOut(vo64));

    // Reference: lowest position >= st that is 0 within the first width bits, -1 if none.
    function automatic int lowest_zero(input logic [63:0] w, input int width, input int st);
        for (int i = st; i < width; i++)
            if (!w[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; v13in = 1'b1; in13 = 13'($urandom);
        repeat (3) begin
            tick();
            n_cmp++;
            if ({vo13, f13, i13} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_hold: got vo=%b f=%b idx=%0d, want 0 0 0", vo13, f13, i13);
            end
        end
        reset = 1'b0; in13 = 13'h1FEF; v13in = 1'b1;
        tick();
        v13in = 1'b0;
        n_cmp++;
        if (vo13 !== 1'b0) begin
            n_bad++;
            $display("FAIL first_word_early: got vo=%b, want 0", vo13);
        end
        tick();
        n_cmp++;
        if ({vo13, f13, i13} !== {1'b1, 1'b1, 4'd4}) begin
            n_bad++;
            $display("FAIL first_word: got vo=%b f=%b idx=%0d, want 1 1 4", vo13, f13, i13);
        end
    endtask

    task automatic test_all_occupied();
        in13 = 13'h1FFF; v13in = 1'b1;
        tick();
        in13 = 13'h0FFF;
        tick();
        v13in = 1'b0;
        n_cmp++;
        if ({vo13, f13, i13} !== {1'b1, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL all_ones: got vo=%b f=%b idx=%0d, want 1 0 0", vo13, f13, i13);
        end
        tick();
        n_cmp++;
        if ({vo13, f13, i13} !== {1'b1, 1'b1, 4'd12}) begin
            n_bad++;
            $display("FAIL top_bit: got vo=%b f=%b idx=%0d, want 1 1 12", vo13, f13, i13);
        end
    endtask

    task automatic test_back_to_back();
        logic [W13-1:0] words [3];
        words[0] = 13'h1FFE; words[1] = 13'h1FFD; words[2] = 13'h1FFB;
        for (int c = 0; c < 5; c++) begin
            v13in = (c < 3);
            if (c < 3) in13 = words[c];
            tick();
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if ({vo13, f13, i13} !== {1'b1, 1'b1, 4'(c - 1)}) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: got vo=%b f=%b idx=%0d, want 1 1 %0d",
                             c - 1, vo13, f13, i13, c - 1);
                end
            end
        end
    endtask

    task automatic test_valid_pattern();
        logic exp_vo;
        in13 = '0;
        for (int c = 0; c < 9; c++) begin
            v13in = (c < 8) && (c % 2 == 0);
            tick();
            exp_vo = (c >= 1) && ((c - 1) % 2 == 0);
            n_cmp++;
            if (vo13 !== exp_vo || (exp_vo && {f13, i13} !== {1'b1, 4'd0})) begin
                n_bad++;
                $display("FAIL valid_pattern[%0d]: got vo=%b f=%b idx=%0d, want vo=%b f=1 idx=0",
                         c, vo13, f13, i13, exp_vo);
            end
        end
    endtask

    task automatic test_reset_flush();
        in13 = '0; v13in = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({vo13, f13, i13} !== 6'b0) begin
            n_bad++;
            $display("FAIL flush_reset: got vo=%b f=%b idx=%0d, want 0 0 0", vo13, f13, i13);
        end
        reset = 1'b0; v13in = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (vo13 !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_no_valid: got vo=%b, want 0", vo13);
            end
        end
    endtask

`ifdef FIRST_ZERO_START_EN
    task automatic test_start();
        int tab [4][3];
        tab[0] = '{5, 1, 12}; tab[1] = '{0, 1, 4}; tab[2] = '{13, 0, 0}; tab[3] = '{15, 0, 0};
        for (int t = 0; t < 4; t++) begin
            in13 = 13'h0FEF; st13 = 4'(tab[t][0]); v13in = 1'b1;
            tick();
            v13in = 1'b0; st13 = '0;
            tick();
            n_cmp++;
            if ({vo13, f13, i13} !== {1'b1, 1'(tab[t][1]), 4'(tab[t][2])}) begin
                n_bad++;
                $display("FAIL start_%0d: got vo=%b f=%b idx=%0d, want 1 %0d %0d",
                         tab[t][0], vo13, f13, i13, tab[t][1], tab[t][2]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic        v13 [N], v5 [N], v64 [N];
        int          e13 [N], e5 [N], e64 [N];
        logic [63:0] w;
        int          j, st_a, st_b, st_c, ei;
        logic        ev, ef;
        for (int c = 0; c < N + S64; c++) begin
            if (c < N) begin
                w = {$urandom, $urandom};
                repeat ($urandom_range(0, 3)) w = w | {$urandom, $urandom};
                if ($urandom_range(0, 9) == 0) w = '1;
                st_a = 0; st_b = 0; st_c = 0;
`ifdef FIRST_ZERO_START_EN
                if ($urandom_range(0, 1) == 1) begin
                    st_a = $urandom_range(0, 15);
                    st_b = $urandom_range(0, 7);
                    st_c = $urandom_range(0, 63);
                end
                st13 = 4'(st_a); st5 = 3'(st_b); st64 = 6'(st_c);
`endif
                in13 = w[12:0]; in5 = w[4:0]; in64 = w;
                v13[c] = ($urandom_range(0, 4) != 0); v13in = v13[c];
                v5[c]  = ($urandom_range(0, 4) != 0); v5in  = v5[c];
                v64[c] = ($urandom_range(0, 4) != 0); v64in = v64[c];
                e13[c] = lowest_zero(w, W13, st_a);
                e5[c]  = lowest_zero(w, W5, st_b);
                e64[c] = lowest_zero(w, W64, st_c);
            end else begin
                v13in = 1'b0; v5in = 1'b0; v64in = 1'b0;
            end
            tick();

            j = c - S13 + 1;
            if (j >= 0) begin
                ev = (j < N) ? v13[j] : 1'b0;
                ef = ev && e13[j < N ? j : 0] >= 0;
                ei = ef ? e13[j] : 0;
                n_cmp++;
                if (vo13 !== ev || (ev && {f13, i13} !== {ef, 4'(ei)})) begin
                    n_bad++;
                    $display("FAIL rand13[%0d]: got vo=%b f=%b idx=%0d, want vo=%b f=%b idx=%0d",
                             j, vo13, f13, i13, ev, ef, ei);
                end
            end
            j = c - S5 + 1;
            if (j >= 0) begin
                ev = (j < N) ? v5[j] : 1'b0;
                ef = ev && e5[j < N ? j : 0] >= 0;
                ei = ef ? e5[j] : 0;
                n_cmp++;
                if (vo5 !== ev || (ev && {f5, i5} !== {ef, 3'(ei)})) begin
                    n_bad++;
                    $display("FAIL rand5[%0d]: got vo=%b f=%b idx=%0d, want vo=%b f=%b idx=%0d",
                             j, vo5, f5, i5, ev, ef, ei);
                end
            end
            j = c - S64 + 1;
            if (j >= 0) begin
                ev = (j < N) ? v64[j] : 1'b0;
                ef = ev && e64[j < N ? j : 0] >= 0;
                ei = ef ? e64[j] : 0;
                n_cmp++;
                if (vo64 !== ev || (ev && {f64, i64} !== {ef, 6'(ei)})) begin
                    n_bad++;
                    $display("FAIL rand64[%0d]: got vo=%b f=%b idx=%0d, want vo=%b f=%b idx=%0d",
                             j, vo64, f64, i64, ev, ef, ei);
                end
            end
        end
    endtask

    initial begin
        in13 = '0; in5 = '0; in64 = '0;
        v13in = 1'b0; v5in = 1'b0; v64in = 1'b0;
        st13 = '0; st5 = '0; st64 = '0;
        test_reset();
        test_all_occupied();
        test_back_to_back();
        test_valid_pattern();
        test_reset_flush();
`ifdef FIRST_ZERO_START_EN
        test_start();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
